// File: rtl/display_port_pkg.sv
// Shared types and constants for the display_port block: FSM states,
// active-low 7-segment codes (gfedcba) and active-low digit enables.
package display_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] AN_UNITS    = 3'b110;
  localparam logic [2:0] AN_TENS     = 3'b101;
  localparam logic [2:0] AN_HUNDREDS = 3'b011;

  // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/display_port_bcd_a_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Ports: digit  - 4-bit BCD value (10..15 decode to blank)
//        blank  - force the digit dark
//        seg_c  - segment drive, active-low, gfedcba
module bcd_a_7seg
  import display_port_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_port.sv
// Memory-mapped 3-digit decimal display port. A CPU write is converted to
// BCD by sequential shift-add-3, committed to the shown digits, and scanned
// onto a multiplexed 7-segment display with leading-zero blanking.
// Ports: clk   - system clock
//        reset - asynchronous active-low reset
//        we/wd - write strobe and 8-bit value
//        seg   - active-low segments (gfedcba), registered
//        an    - active-low one-hot digit enable, registered
//        busy  - conversion running or write pending, registered
module display_port
  import display_port_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wd,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state, state_n;
  logic [7:0]        shadow, shadow_n;
  logic              pend, pend_n;
  logic [7:0]        pend_val, pend_val_n;
  logic [11:0]       bcd, bcd_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [11:0]       disp, disp_n;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_n;
  logic [1:0]        dig_idx, dig_idx_n;

  logic [11:0]       bcd_adj;
  logic [19:0]       dd_word;
  logic [3:0]        nib_c;
  logic              blank_c;
  logic [2:0]        an_n;
  logic [6:0]        seg_n;

  // Conversion FSM and pending-write capture.
  always_comb begin
    state_n    = state;
    shadow_n   = shadow;
    pend_n     = pend;
    pend_val_n = pend_val;
    bcd_n      = bcd;
    bit_cnt_n  = bit_cnt;
    disp_n     = disp;
    bcd_adj    = {dd_adjust(bcd[11:8]), dd_adjust(bcd[7:4]), dd_adjust(bcd[3:0])};
    dd_word    = {bcd_adj, shadow} << 1;

    case (state)
      ST_IDLE: begin
        if (we) begin
          shadow_n  = wd;
          bcd_n     = '0;
          bit_cnt_n = '0;
          state_n   = ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_n     = dd_word[19:8];
        shadow_n  = dd_word[7:0];
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = ST_COMMIT;
        if (we) begin
          pend_n     = 1'b1;
          pend_val_n = wd;
        end
      end
      ST_COMMIT: begin
        disp_n = bcd;
        // A write landing in this cycle is the newest value, so it starts
        // the next conversion directly and supersedes any older pending one.
        if (we || pend) begin
          shadow_n  = we ? wd : pend_val;
          pend_n    = 1'b0;
          bcd_n     = '0;
          bit_cnt_n = '0;
          state_n   = ST_CONV;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Free-running scan divider and digit index.
  always_comb begin
    scan_cnt_n = scan_cnt + SCAN_W'(1);
    dig_idx_n  = dig_idx;
    if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_n = '0;
      dig_idx_n  = (dig_idx == 2'd2) ? 2'd0 : (dig_idx + 2'd1);
    end
  end

  // Digit select with leading-zero blanking, based on next-cycle values so
  // seg/an register in step with disp and the digit index.
  always_comb begin
    nib_c   = disp_n[3:0];
    blank_c = 1'b0;
    an_n    = AN_UNITS;
    case (dig_idx_n)
      2'd1: begin
        nib_c   = disp_n[7:4];
        blank_c = (disp_n[11:4] == 8'd0);
        an_n    = AN_TENS;
      end
      2'd2: begin
        nib_c   = disp_n[11:8];
        blank_c = (disp_n[11:8] == 4'd0);
        an_n    = AN_HUNDREDS;
      end
      default: begin
        nib_c   = disp_n[3:0];
        blank_c = 1'b0;
        an_n    = AN_UNITS;
      end
    endcase
  end

  bcd_a_7seg u_dec (
    .digit (nib_c),
    .blank (blank_c),
    .seg_c (seg_n)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shadow   <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      disp     <= '0;
      scan_cnt <= '0;
      dig_idx  <= '0;
      seg      <= SEG_0;
      an       <= AN_UNITS;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      pend     <= pend_n;
      pend_val <= pend_val_n;
      bcd      <= bcd_n;
      bit_cnt  <= bit_cnt_n;
      disp     <= disp_n;
      scan_cnt <= scan_cnt_n;
      dig_idx  <= dig_idx_n;
      seg      <= seg_n;
      an       <= an_n;
      busy     <= (state_n != ST_IDLE) || pend_n;
    end
  end

endmodule

// File: tb/tb_display_port.sv
// Self-checking bench for display_port with SCAN_DIV=4: table-driven writes
// plus hand-written sequences for pending writes, COMMIT-cycle writes and
// reset during conversion.
module tb_display_port;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic [7:0] wd;
    logic [6:0] sh;
    logic [6:0] st;
    logic [6:0] su;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       we;
  logic [7:0] wd;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int   checks;
  int   errors;
  int   cyc;
  vec_t cur;
  vec_t vecs [7];

  display_port #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wd    (wd),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Advance one clock and compare an/seg against the expected shown value
  // for the digit the scan should be on, plus busy.
  task automatic tick_chk(input logic exp_busy);
    int         idx;
    logic [2:0] ea;
    logic [6:0] es;
    @(posedge clk);
    #1;
    cyc++;
    idx = (cyc / 4) % 3;
    case (idx)
      0:       begin ea = 3'b110; es = cur.su; end
      1:       begin ea = 3'b101; es = cur.st; end
      default: begin ea = 3'b011; es = cur.sh; end
    endcase
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  // Single write on an idle block: busy for exactly 9 cycles, then shown.
  task automatic do_write(input vec_t v);
    we = 1'b1;
    wd = v.wd;
    tick_chk(1'b1);
    we = 1'b0;
    repeat (8) tick_chk(1'b1);
    cur = v;
    tick_chk(1'b0);
    repeat (11) tick_chk(1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    cur   = '{8'd0, SB, SB, S0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    we     = 1'b0;
    wd     = 8'd0;
    reset  = 1'b1;
    cur    = '{8'd0, SB, SB, S0};

    vecs[0] = '{8'd255, S2, S5, S5};
    vecs[1] = '{8'd7,   SB, SB, S7};
    vecs[2] = '{8'd100, S1, S0, S0};
    vecs[3] = '{8'd0,   SB, SB, S0};
    vecs[4] = '{8'd10,  SB, S1, S0};
    vecs[5] = '{8'd138, S1, S3, S8};
    vecs[6] = '{8'd206, S2, S0, S6};

    // Reset values
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_an", 32'(an), 32'(3'b110));
    chk("rst_seg", 32'(seg), 32'(S0));
    @(posedge clk);
    @(posedge clk);
    release_reset();

    // Idle scan of "0"
    repeat (12) tick_chk(1'b0);

    // Table-driven single writes
    for (int i = 0; i < 7; i++) do_write(vecs[i]);

    // 42, then 130 two cycles later, then 9: 130 is never shown
    we = 1'b1; wd = 8'd42;
    tick_chk(1'b1);
    we = 1'b0;
    tick_chk(1'b1);
    we = 1'b1; wd = 8'd130;
    tick_chk(1'b1);
    wd = 8'd9;
    tick_chk(1'b1);
    we = 1'b0;
    repeat (5) tick_chk(1'b1);
    cur = '{8'd42, SB, S4, S2};
    tick_chk(1'b1);
    repeat (8) tick_chk(1'b1);
    cur = '{8'd9, SB, SB, S9};
    tick_chk(1'b0);
    repeat (12) tick_chk(1'b0);

    // 200, with 201 written in the COMMIT cycle
    we = 1'b1; wd = 8'd200;
    tick_chk(1'b1);
    we = 1'b0;
    repeat (8) tick_chk(1'b1);
    we = 1'b1; wd = 8'd201;
    cur = '{8'd200, S2, S0, S0};
    tick_chk(1'b1);
    we = 1'b0;
    repeat (8) tick_chk(1'b1);
    cur = '{8'd201, S2, S0, S1};
    tick_chk(1'b0);
    repeat (12) tick_chk(1'b0);

    // Reset during the 4th conversion cycle of 88
    we = 1'b1; wd = 8'd88;
    tick_chk(1'b1);
    we = 1'b0;
    repeat (3) tick_chk(1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(1'b0));
    chk("midrst_an", 32'(an), 32'(3'b110));
    chk("midrst_seg", 32'(seg), 32'(S0));
    release_reset();
    repeat (15) tick_chk(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_port.md
# display_port

Memory-mapped output port that turns an 8-bit value written by the CPU into a three-digit decimal readout on a time-multiplexed 7-segment display. It sits downstream of the I/O write demultiplexer: the port's write strobe and data come from the CPU's output path. Binary-to-BCD conversion is sequential (shift-add-3, one bit per cycle), and the digits are scanned by a programmable divider.

## Interface
- SCAN_DIV, 50000: clk cycles each digit stays enabled; legal range is 2 or more.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- we  in  1  write strobe; data is sampled on the rising edge when high.
- wd  in  8  unsigned value to display, 0..255.
- seg  out  7  segment drive, active-low, bit order gfedcba. Codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - blank=1111111
- an  out  3  digit enables, active-low one-hot: 110=units, 101=tens, 011=hundreds.
- busy  out  1  high while a conversion or a pending write is outstanding.

## Operation
- Registers:
  - shadow: 8-bit conversion operand.
  - pend flag and pend value: one-deep pending write.
  - bcd: 12-bit double-dabble accumulator.
  - bit counter: 0..7.
  - disp: 12-bit shown digits.
  - scan counter: 0..SCAN_DIV-1.
  - digit index: 0..2.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE, we=1: load shadow=wd, clear bcd and bit counter, go to CONV.
  - CONV: each cycle, first add 3 to any bcd nibble that is 5 or more, then shift {bcd,shadow} left by 1. After the 8th shift, go to COMMIT.
  - COMMIT: disp<=bcd. If pend=1, load shadow=pend value, clear pend, go to CONV. Otherwise go to IDLE.
- Writes while not in IDLE, including in COMMIT:
  - The write goes to pend (pend=1, pend value=wd).
  - A later write overwrites an earlier one (last write wins). Only the newest pending value is ever displayed.
- busy = (state!=IDLE) | pend.
- Leading-zero blanking:
  - Hundreds is blanked when it is 0.
  - Tens is blanked when both hundreds and tens are 0.
  - Units is always lit.
- Scan:
  - The scan counter runs continuously.
  - When it wraps at SCAN_DIV-1, the digit index advances 0→1→2→0.
  - seg shows the decoded disp nibble for the current index; an is the matching one-hot.
  - A disp update never resets the scan.
- Reset values:
  - state=IDLE, pend=0, shadow=0, bcd=0, disp=0.
  - Scan counter=0, digit index=0.
  - Outputs: busy=0, an=110, seg=1000000 (units "0").
- Reset mid-conversion: the conversion and any pending value are discarded, and disp returns to 0.

## Timing
- A write sampled at edge k on an idle block:
  - busy=1 from edge k.
  - Shifts happen at edges k+1..k+8.
  - disp updates at edge k+9.
  - busy falls at edge k+9 if nothing is pending.
- Latency from write to visible digits is 9 cycles. Back-to-back conversions are 9 cycles apart.
- we in the same cycle as COMMIT: the value is captured into pend and conversion restarts at edge k+1 with no idle cycle.
- seg and an are registered outputs. They change only on a scan wrap or on a disp update; there is no combinational path from wd.
- Digit period is SCAN_DIV cycles. The full refresh frame is 3×SCAN_DIV cycles.

## Structure
- Shared package holds:
  - FSM state enum.
  - The 7-segment code constants, including blank.
  - Digit-enable constants.
- One sub-module, bcd_a_7seg: combinational 4-bit BCD plus blank input to 7-bit active-low segments.
  - Nibble values 10..15 map to blank.
- Everything else (FSM, datapath, scan) stays in display_port.

## Test plan
All scenarios use SCAN_DIV=4 on the bench.
- Reset, then idle for 12 cycles → an cycles 110,101,011 every 4 cycles; seg is 1000000 on units and 1111111 on tens/hundreds; busy=0.
- Write wd=255 → busy high for exactly 9 cycles, then disp=0x255 and seg shows 2, 5, 5 on their digits.
- Write 7 → units 1111000, tens and hundreds blank. Write 100 → 0011001 is wrong; required digits are 1, 0, 0 with no blanking, since the tens zero is not a leading zero.
- Write 42, then 130 two cycles later, then 9 one cycle after that → the display shows 42, then 9 (130 never appears); busy stays high continuously until 9 is committed.
- Write 200 with we also asserted in the COMMIT cycle carrying 201 → 200 is committed, 201 is committed exactly 9 cycles later, and busy never drops between them.
- Assert reset at the 4th CONV cycle of a write of 88 → all outputs return immediately to their reset values; after release, no commit of 88 occurs.
